// File: rtl/sr_bank_arbiter_if.sv
// Request/command bus shared by the SR bank arbiter and its requesters and bank.
// The master side drives requests and bank read-back; the slave side is the arbiter.
interface sr_bank_arbiter_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned NBITS = 8,
    parameter int unsigned AW    = 3
);
    logic [NREQ-1:0]    req;
    logic [2*NREQ-1:0]  op;
    logic [AW*NREQ-1:0] addr;
    logic [NBITS-1:0]   q_in;
    logic [NBITS-1:0]   S;
    logic [NBITS-1:0]   R;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic               busy;

    modport master (
        output req, op, addr, q_in,
        input  S, R, gnt, done, err, busy
    );

    modport slave (
        input  req, op, addr, q_in,
        output S, R, gnt, done, err, busy
    );
endinterface

// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter that turns granted requests into single S/R pulses on a shared
// bank of clocked SR cells, verifies each write by read-back and retries or flags failures.
module sr_bank_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned NBITS     = 8,
    parameter int unsigned AW        = 3,
    parameter int unsigned MAX_RETRY = 2
) (
    input logic              clk,
    input logic              rst,
    sr_bank_arbiter_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned NA = 1 << AW;

    typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    w_q, w_d;
    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [NBITS-1:0] s_q, s_d, r_q, r_d;
    logic [NREQ-1:0]  gnt_q, gnt_d, done_q, done_d;
    logic             err_q, err_d, busy_q, busy_d;

    logic             found;
    logic [PW-1:0]    cand, win;
    logic [1:0]       win_op, cur_op;
    logic [AW-1:0]    win_addr, cur_addr;
    logic             win_legal;
    logic [NREQ-1:0]  win_oh, w_oh;
    logic [NBITS-1:0] s_drv, r_drv;
    logic [NA-1:0]    q_ext;
    logic             check_ok;

    // Winner is the first asserted request at or after the pointer, wrapping.
    always_comb begin
        found = 1'b0;
        cand  = '0;
        win   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = PW'((int'(ptr_q) + k) % int'(NREQ));
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        win_op    = bus.op[2*int'(win) +: 2];
        win_addr  = bus.addr[AW*int'(win) +: AW];
        win_legal = (win_op != 2'b11) && (int'(win_addr) < int'(NBITS));
        win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << win;
        w_oh      = {{(NREQ-1){1'b0}}, 1'b1} << w_q;
    end

    // First drive uses the freshly arbitrated command, re-drives use the latched one.
    always_comb begin
        cur_op   = (state_q == StIdle) ? win_op : op_q;
        cur_addr = (state_q == StIdle) ? win_addr : addr_q;
        s_drv    = '0;
        r_drv    = '0;
        for (int i = 0; i < int'(NBITS); i++) begin
            s_drv[i] = (cur_op == 2'b01) && (int'(cur_addr) == i);
            r_drv[i] = (cur_op == 2'b10) && (int'(cur_addr) == i);
        end
        q_ext            = '0;
        q_ext[NBITS-1:0] = bus.q_in;
        case (op_q)
            2'b01:   check_ok = q_ext[addr_q];
            2'b10:   check_ok = !q_ext[addr_q];
            default: check_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        op_d    = op_q;
        addr_d  = addr_q;
        retry_d = retry_q;
        s_d     = '0;
        r_d     = '0;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (found) begin
                    w_d     = win;
                    op_d    = win_op;
                    addr_d  = win_addr;
                    retry_d = '0;
                    if (win_legal) begin
                        state_d = StDrive;
                        gnt_d   = win_oh;
                        s_d     = s_drv;
                        r_d     = r_drv;
                    end else begin
                        state_d = StDone;
                        done_d  = win_oh;
                        err_d   = 1'b1;
                    end
                end
            end
            StDrive: begin
                state_d = StCheck;
                gnt_d   = w_oh;
            end
            StCheck: begin
                if (check_ok) begin
                    state_d = StDone;
                    done_d  = w_oh;
                end else if (retry_q < RW'(MAX_RETRY)) begin
                    state_d = StDrive;
                    retry_d = retry_q + RW'(1);
                    gnt_d   = w_oh;
                    s_d     = s_drv;
                    r_d     = r_drv;
                end else begin
                    state_d = StDone;
                    done_d  = w_oh;
                    err_d   = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                ptr_d   = PW'((int'(w_q) + 1) % int'(NREQ));
                retry_d = '0;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            w_q     <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            retry_q <= '0;
            s_q     <= '0;
            r_q     <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            retry_q <= retry_d;
            s_q     <= s_d;
            r_q     <= r_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.S    = s_q;
    assign bus.R    = r_q;
    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
    assign bus.busy = busy_q;
endmodule

// File: doc/sr_bank_arbiter.md
Name: sr_bank_arbiter

Overview:
Round-robin arbiter and command sequencer that shares a bank of NBITS clocked SR flip-flops between NREQ requesters. Each granted request is turned into a one-cycle S or R pulse on one cell, then verified by reading back that cell's Q. The bank output is fed back on q_in. The block never drives S=R=1 on any cell, and retries or flags writes that do not take effect.

Parameters:
NREQ, 4, number of requesters (2..8)
NBITS, 8, number of SR cells in the bank
AW, 3, cell address width; NBITS <= 2**AW
MAX_RETRY, 2, re-drive attempts after a failed read-back before flagging an error

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  NREQ  per-requester request; held high until that requester's done
op  in  2*NREQ  per-requester command [2i+1:2i]: 00 hold, 01 set, 10 reset, 11 illegal
addr  in  AW*NREQ  per-requester cell address [AW*i+AW-1:AW*i]
q_in  in  NBITS  Q outputs of the SR bank
S  out  NBITS  set lines to the bank, one-hot or zero
R  out  NBITS  reset lines to the bank, one-hot or zero
gnt  out  NREQ  one-hot grant, high for the whole transaction
done  out  NREQ  one-cycle completion pulse to the winner
err  out  1  one-cycle pulse coincident with done on failure
busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: S, R, gnt, done, err and busy are all 0. State is IDLE, the round-robin pointer is 0 and the retry count is 0.
- Reset mid-transaction: S and R drop to 0 immediately; the transaction is abandoned and no done is issued.
- Outputs: all outputs are registered.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE:
  - req is sampled only in IDLE, at the clock edge.
  - Winner = first asserted req at index ptr, ptr+1, ... wrapping modulo NREQ.
  - The winner's op and addr are latched at that edge; later changes to req, op or addr are ignored.
  - If no req is asserted, the block stays in IDLE.
- Illegal op (11): IDLE -> DONE directly. gnt is never asserted and no S/R is driven; done[w] and err pulse in DONE.
- Out-of-range addr (>= NBITS): handled identically to an illegal op.
- DRIVE (one cycle):
  - gnt[w]=1.
  - op 01: S[addr]=1. op 10: R[addr]=1. op 00: no line driven.
  - All other S and R bits are 0; S and R are never both high on any bit.
  - DRIVE -> CHECK.
- CHECK (one cycle):
  - gnt[w] stays 1; S and R are 0.
  - Expected value: 1 for set, 0 for reset. Hold always passes.
  - If q_in[addr] equals the expected value: -> DONE.
  - On mismatch with retry count < MAX_RETRY: increment the count and -> DRIVE.
  - On mismatch with count == MAX_RETRY: -> DONE with err.
- DONE (one cycle):
  - done[w]=1; err=1 if the transaction failed.
  - gnt drops to 0 at the start of DONE.
  - ptr <= (w+1) mod NREQ; retry count cleared.
  - DONE -> IDLE.
- Latency, legal op with no retry: req sampled at edge E0 gives DRIVE in cycle 1, CHECK in cycle 2, done in cycle 3. Each retry adds 2 cycles. Illegal op: done in cycle 1.
- Requester rule: req must be low by the first IDLE cycle after its done; otherwise the request is re-arbitrated as new.
- Simultaneous requests: strictly round-robin, so no requester waits more than NREQ-1 transactions.
- Throughput: at most one transaction in flight.

Test Plan:
- rst=1 mid-DRIVE with S[3]=1 -> S, R, gnt and busy go to 0 before the next clk edge; after release the block is in IDLE, ptr=0, and no done is issued.
- Single requester, req[1]=1, op=01, addr=5, bank model behaving correctly -> S[5]=1 in cycle 1 only, gnt=4'b0010 in cycles 1-2, done=4'b0010 in cycle 3, err=0, bank Q[5]=1.
- All four req high, each op=10 on a different addr, held until done -> grants in order 0,1,2,3, each 4 cycles apart. Then req[0] re-raised together with req[2] -> req[0] granted first (ptr=0).
- req[2]=1 with op=11 -> done[2] and err pulse in cycle 1; S=R=0 and gnt=0 throughout.
- Bank model with q_in[6] stuck at 0, op=01, addr=6 -> S[6] pulses 3 times (initial + MAX_RETRY=2), 2 cycles apart; done and err pulse together in cycle 7.
- Randomised ops on all requesters for 2000 cycles -> assert S&R==0 every cycle, gnt one-hot or zero, and exactly one done per accepted request.
